m_imem_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the processor's instruction/data memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words into memory from word address 0 through a single write port, then releases the processor by asserting `w_run`. It replaces direct memory pokes as the way programs enter the core.

---
 rtl/m_imem_loader_pkg.sv | 35 +++
 rtl/m_imem_loader_if.sv | 24 ++
 rtl/m_imem_loader_word_asm.sv | 32 +++
 rtl/m_imem_loader.sv | 162 ++++++++++++++++
 tb/tb_m_imem_loader.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m_imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader:
// FSM state encodings, default address width and a state helper.
package m_imem_loader_pkg;

    localparam int ADDR_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_HDR0 = 3'd0,
        ST_HDR1 = 3'd1,
        ST_DATA = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM = 3'd3,
`endif
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    // State entered once the data phase (or empty header) is finished.
`ifdef LOADER_CHECKSUM_EN
    localparam state_e ST_FIN = ST_CSUM;
`else
    localparam state_e ST_FIN = ST_DONE;
`endif

    // States in which the loader takes bytes from the stream.
    function automatic logic st_accepts(state_e s);
        logic r;
        r = (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA);
`ifdef LOADER_CHECKSUM_EN
        r = r || (s == ST_CSUM);
`endif
        return r;
    endfunction

endpackage

// File: rtl/m_imem_loader_if.sv
// Byte-stream input handshake plus memory write port of the loader.
// slave: loader side; master: stream source / memory observer side.
interface m_imem_loader_if
    import m_imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              w_in_valid;
    logic [7:0]        w_in_data;
    logic              w_in_ready;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [31:0]       w_wdata;

    modport slave (
        input  w_in_valid, w_in_data,
        output w_in_ready, w_we, w_waddr, w_wdata
    );

    modport master (
        output w_in_valid, w_in_data,
        input  w_in_ready, w_we, w_waddr, w_wdata
    );
endinterface

// File: rtl/m_imem_loader_word_asm.sv
// m_word_asm: shifts bytes in little-endian order into a 32-bit word.
// Ports: i_clr drops a partial word, i_en takes i_byte, o_done/o_word.
module m_word_asm (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic        o_done,
    output logic [31:0] o_word
);
    logic [1:0]  r_idx;
    logic [23:0] r_word;

    // Word completes combinationally with the 4th byte so the top
    // can register it on the same edge the byte is accepted.
    assign o_done = i_en && (r_idx == 2'd3);
    assign o_word = {i_byte, r_word};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx  <= 2'd0;
            r_word <= 24'd0;
        end else if (i_clr) begin
            r_idx  <= 2'd0;
            r_word <= 24'd0;
        end else if (i_en) begin
            r_idx  <= r_idx + 2'd1;
            r_word <= {i_byte, r_word[23:8]};
        end
    end
endmodule

// File: rtl/m_imem_loader.sv
// m_imem_loader: loads a counted little-endian word stream into memory
// from address 0, then raises w_run (or w_err on a bad stream).
// Ports: w_clk, w_rst_n, w_restart, bus (byte in + write port),
// w_run, w_err. Optional trailing XOR byte: LOADER_CHECKSUM_EN.
module m_imem_loader
    import m_imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic               w_clk,
    input  logic               w_rst_n,
    input  logic               w_restart,
    m_imem_loader_if.slave     bus,
    output logic               w_run,
    output logic               w_err
);
    // 17-bit depth so a 65536-word memory still compares correctly.
    localparam logic [16:0] DEPTH17 = 17'(64'd1 << ADDR_W);

    state_e            r_state;
    state_e            w_state_nx;
    logic              r_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic              r_run;
    logic              r_err;
    logic [15:0]       r_n;
    logic [15:0]       r_wcnt;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_xor;
`endif

    logic              w_xfer;
    logic              w_asm_clr;
    logic              w_asm_en;
    logic              w_done;
    logic [31:0]       w_word;
    logic [16:0]       w_n17;

    assign w_xfer = bus.w_in_valid && r_ready;
    assign w_n17  = {1'b0, bus.w_in_data, r_n[7:0]};

    assign bus.w_in_ready = r_ready;
    assign bus.w_we       = r_we;
    assign bus.w_waddr    = r_waddr;
    assign bus.w_wdata    = r_wdata;
    assign w_run          = r_run;
    assign w_err          = r_err;

    m_word_asm u_asm (
        .i_clk   (w_clk),
        .i_rst_n (w_rst_n),
        .i_clr   (w_asm_clr),
        .i_en    (w_asm_en),
        .i_byte  (bus.w_in_data),
        .o_done  (w_done),
        .o_word  (w_word)
    );

    always_comb begin
        w_state_nx = r_state;
        w_asm_clr  = 1'b0;
        w_asm_en   = 1'b0;
        unique case (r_state)
            ST_HDR0: begin
                w_asm_clr = 1'b1;
                if (w_xfer) w_state_nx = ST_HDR1;
            end
            ST_HDR1: begin
                w_asm_clr = 1'b1;
                if (w_xfer) begin
                    if (w_n17 > DEPTH17)
                        w_state_nx = ST_ERR;
                    else if (w_n17 == 17'd0)
                        w_state_nx = ST_FIN;
                    else
                        w_state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                w_asm_en = w_xfer;
                if (w_done && (r_wcnt == r_n - 16'd1))
                    w_state_nx = ST_FIN;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (w_xfer)
                    w_state_nx = (bus.w_in_data == r_xor) ?
                                 ST_DONE : ST_ERR;
            end
`endif
            ST_DONE: w_state_nx = ST_DONE;
            ST_ERR:  w_state_nx = ST_ERR;
            default: w_state_nx = ST_ERR;
        endcase
        // Restart wins over any byte offered in the same cycle.
        if (w_restart) begin
            w_state_nx = ST_HDR0;
            w_asm_clr  = 1'b1;
            w_asm_en   = 1'b0;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= ST_HDR0;
        else          r_state <= w_state_nx;
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= 32'd0;
            r_run   <= 1'b0;
            r_err   <= 1'b0;
            r_n     <= 16'd0;
            r_wcnt  <= 16'd0;
        end else if (w_restart) begin
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= 32'd0;
            r_run   <= 1'b0;
            r_err   <= 1'b0;
            r_n     <= 16'd0;
            r_wcnt  <= 16'd0;
        end else begin
            // Status outputs trail the state by one edge.
            r_ready <= st_accepts(r_state);
            r_run   <= (r_state == ST_DONE);
            r_err   <= (r_state == ST_ERR);
            r_we    <= w_done;
            if (w_done) begin
                r_wdata <= w_word;
                r_wcnt  <= r_wcnt + 16'd1;
            end
            // Advance after the write cycle; holds at the last address.
            if (r_we && (r_state == ST_DATA))
                r_waddr <= r_waddr + 1'b1;
            if (w_xfer && (r_state == ST_HDR0))
                r_n[7:0] <= bus.w_in_data;
            if (w_xfer && (r_state == ST_HDR1))
                r_n[15:8] <= bus.w_in_data;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n)
            r_xor <= 8'd0;
        else if (w_restart)
            r_xor <= 8'd0;
        else if (w_xfer && ((r_state == ST_HDR0) ||
                            (r_state == ST_HDR1) ||
                            (r_state == ST_DATA)))
            r_xor <= r_xor ^ bus.w_in_data;
    end
`endif

endmodule

// File: tb/tb_m_imem_loader.sv
// Directed bench for m_imem_loader: full-rate and throttled loads,
// empty/oversize headers, reset/restart mid-load, optional checksum.
module tb_m_imem_loader;
    import m_imem_loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic restart;
    logic run;
    logic err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    int          run_cyc;
    int          t0;
    int          d1;
    int          d2;
    int          k;

    m_imem_loader_if #(.ADDR_W(8)) bus ();

    m_imem_loader #(.ADDR_W(8)) dut (
        .w_clk     (clk),
        .w_rst_n   (rst_n),
        .w_restart (restart),
        .bus       (bus),
        .w_run     (run),
        .w_err     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.w_we) begin
            wa_q.push_back(bus.w_waddr);
            wd_q.push_back(bus.w_wdata);
            wc_q.push_back(cyc);
        end
        if (run && run_cyc < 0) run_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        run_cyc = -1;
        t0 = cyc;
    endtask

    task automatic send(input logic [7:0] b, input bit slow);
        int t;
        if (slow) begin
            @(negedge clk);
            bus.w_in_valid = 1'b0;
        end
        @(negedge clk);
        bus.w_in_valid = 1'b1;
        bus.w_in_data  = b;
        t = 0;
        while (!bus.w_in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ready_timeout", 32'(t), 32'd0);
        @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit slow);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8], slow);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.w_in_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        bus.w_in_valid = 1'b0;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic wait_run();
        for (int i = 0; i < 20 && run_cyc < 0; i++) @(negedge clk);
    endtask

    task automatic chk_wr(input string tag, input int i,
                          input logic [7:0] a, input logic [31:0] d);
        logic [7:0]  oa;
        logic [31:0] od;
        oa = (i < wa_q.size()) ? wa_q[i] : 8'hxx;
        od = (i < wd_q.size()) ? wd_q[i] : 32'hxxxxxxxx;
        chk({tag, "_addr"}, 32'(oa), 32'(a));
        chk({tag, "_data"}, od, d);
    endtask

    task automatic load3(input bit slow);
        send(8'h03, slow);
        send(8'h00, slow);
        send_word(32'h00700093, slow);
        send_word(32'h00102423, slow);
        send_word(32'h00802183, slow);
        idle();
        wait_run();
    endtask

    task automatic chk_load3(input string tag);
        chk({tag, "_nwr"}, 32'(wa_q.size()), 32'd3);
        chk_wr({tag, "_w0"}, 0, 8'd0, 32'h00700093);
        chk_wr({tag, "_w1"}, 1, 8'd1, 32'h00102423);
        chk_wr({tag, "_w2"}, 2, 8'd2, 32'h00802183);
        chk({tag, "_run_at"}, 32'(run_cyc),
            (wc_q.size() == 3) ? 32'(wc_q[2] + 1) : 32'hffffffff);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        restart = 1'b0;
        bus.w_in_valid = 1'b0;
        bus.w_in_data = 8'h00;
        run_cyc = -1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.w_in_ready), 32'd0);
        chk("rst_we",    32'(bus.w_we),       32'd0);
        chk("rst_waddr", 32'(bus.w_waddr),    32'd0);
        chk("rst_wdata", bus.w_wdata,         32'd0);
        chk("rst_run",   32'(run),            32'd0);
        chk("rst_err",   32'(err),            32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(bus.w_in_ready), 32'd1);

        // Full rate: writes every 4 cycles.
        clear_log();
        load3(1'b0);
        chk_load3("full");
        chk("full_gap01",
            (wc_q.size() == 3) ? 32'(wc_q[1] - wc_q[0]) : 32'd0, 32'd4);
        chk("full_gap12",
            (wc_q.size() == 3) ? 32'(wc_q[2] - wc_q[1]) : 32'd0, 32'd4);
        d1 = run_cyc - t0;

        // Restart from DONE, then throttled load.
        pulse_restart();
        chk("rs_run",   32'(run),         32'd0);
        chk("rs_waddr", 32'(bus.w_waddr), 32'd0);
        clear_log();
        load3(1'b1);
        chk_load3("slow");
        d2 = run_cyc - t0;
        chk("slow_longer", 32'(d2 >= d1 + 12), 32'd1);

`ifndef LOADER_CHECKSUM_EN
        // Empty program: run one edge after the second header byte.
        pulse_restart();
        clear_log();
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        idle();
        k = cyc;
        wait_run();
        chk("empty_run_at", 32'(run_cyc), 32'(k + 1));
        chk("empty_nwr", 32'(wa_q.size()), 32'd0);
`endif

        // Oversize count: 257 > 256 words.
        pulse_restart();
        clear_log();
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        idle();
        chk("big_err_early", 32'(err), 32'd0);
        @(negedge clk);
        chk("big_err",   32'(err),            32'd1);
        chk("big_ready", 32'(bus.w_in_ready), 32'd0);
        chk("big_run",   32'(run),            32'd0);
        chk("big_nwr",   32'(wa_q.size()),    32'd0);

        // Reset after 6 data bytes of a 2-word load.
        pulse_restart();
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        send_word(32'h11223344, 1'b0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        idle();
        chk("mid_waddr", 32'(bus.w_waddr), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_ready", 32'(bus.w_in_ready), 32'd0);
        chk("mr_we",    32'(bus.w_we),       32'd0);
        chk("mr_waddr", 32'(bus.w_waddr),    32'd0);
        chk("mr_wdata", bus.w_wdata,         32'd0);
        chk("mr_run",   32'(run),            32'd0);
        chk("mr_err",   32'(err),            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        send_word(32'hcafef00d, 1'b0);
        send_word(32'h0badbeef, 1'b0);
        idle();
        wait_run();
        chk("rl_nwr", 32'(wa_q.size()), 32'd2);
        chk_wr("rl_w0", 0, 8'd0, 32'hcafef00d);
        chk_wr("rl_w1", 1, 8'd1, 32'h0badbeef);

        // Restart mid-load with a byte offered on the restart edge.
        pulse_restart();
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        send_word(32'h11223344, 1'b0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        @(negedge clk);
        restart = 1'b1;
        bus.w_in_valid = 1'b1;
        bus.w_in_data = 8'haa;
        @(negedge clk);
        restart = 1'b0;
        bus.w_in_valid = 1'b0;
        chk("mx_we",    32'(bus.w_we),    32'd0);
        chk("mx_waddr", 32'(bus.w_waddr), 32'd0);
        chk("mx_wdata", bus.w_wdata,      32'd0);
        chk("mx_run",   32'(run),         32'd0);
        chk("mx_err",   32'(err),         32'd0);
        clear_log();
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        send_word(32'h01020304, 1'b0);
        send_word(32'ha0b0c0d0, 1'b0);
        idle();
        wait_run();
        chk("rx_nwr", 32'(wa_q.size()), 32'd2);
        chk_wr("rx_w0", 0, 8'd0, 32'h01020304);
        chk_wr("rx_w1", 1, 8'd1, 32'ha0b0c0d0);

`ifdef LOADER_CHECKSUM_EN
        // XOR of 01 00 93 00 70 00 is e2.
        pulse_restart();
        clear_log();
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send_word(32'h00700093, 1'b0);
        send(8'he2, 1'b0);
        idle();
        wait_run();
        chk("cs_ok_run", 32'(run), 32'd1);
        chk("cs_ok_err", 32'(err), 32'd0);
        chk_wr("cs_ok_w0", 0, 8'd0, 32'h00700093);
        pulse_restart();
        clear_log();
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send_word(32'h00700093, 1'b0);
        send(8'he3, 1'b0);
        idle();
        @(negedge clk);
        chk("cs_bad_err", 32'(err), 32'd1);
        chk("cs_bad_run", 32'(run), 32'd0);
        chk_wr("cs_bad_w0", 0, 8'd0, 32'h00700093);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
